// File: rtl/ahb_sram_pkg.sv
// Shared types and bus encodings for the AHB-Lite to single-port SRAM slave.
package ahb_sram_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RD_STALL,
        S_WR,
        S_ERR1,
        S_ERR2
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic [1:0] HRESP_OKAY    = 2'd0;
    localparam logic [1:0] HRESP_ERROR   = 2'd1;

    localparam logic [2:0] HSIZE_BYTE    = 3'd0;
    localparam logic [2:0] HSIZE_HALF    = 3'd1;
    localparam logic [2:0] HSIZE_WORD    = 3'd2;

endpackage

// File: rtl/ahb_sram_be_gen.sv
// Byte-lane enable generation and transfer legality check.
// Macro AHB_SRAM_ERR_RESP_EN enables the size/alignment/range check;
// without it o_bad is tied low and the address is force-aligned by the lanes.
module ahb_sram_be_gen
    import ahb_sram_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024,
    parameter int SRAM_AW    = $clog2(MEM_DEPTH)
) (
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [2:0]            i_size,
    output logic [3:0]            o_be,
    output logic                  o_bad
);

    logic w_unused;
    assign w_unused = ^i_addr[ADDR_WIDTH-1:2];

    // Little-endian lane select; any size above half is a full word.
    always_comb begin
        o_be = 4'b1111;
        case (i_size)
            HSIZE_BYTE: o_be = 4'b0001 << i_addr[1:0];
            HSIZE_HALF: o_be = i_addr[1] ? 4'b1100 : 4'b0011;
            default:    o_be = 4'b1111;
        endcase
    end

`ifdef AHB_SRAM_ERR_RESP_EN
    logic w_misalign;
    logic w_oor;

    if (ADDR_WIDTH > SRAM_AW + 2) begin : g_range
        assign w_oor = |i_addr[ADDR_WIDTH-1:SRAM_AW+2];
    end else begin : g_norange
        assign w_oor = 1'b0;
    end

    // Natural alignment check for the requested size.
    always_comb begin
        w_misalign = 1'b0;
        case (i_size)
            HSIZE_HALF: w_misalign = i_addr[0];
            HSIZE_WORD: w_misalign = |i_addr[1:0];
            default:    w_misalign = 1'b0;
        endcase
    end

    assign o_bad = (i_size > HSIZE_WORD) | w_misalign | w_oor;
`else
    assign o_bad = 1'b0;
`endif

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave in front of a single-port synchronous SRAM (1-cycle read).
// Reads are launched in the address phase so data lands in the data phase;
// a read right after a write data phase loses the port and stalls once.
// Macro AHB_SRAM_ERR_RESP_EN enables the two-cycle ERROR response path.
module ahb_sram_slave
    import ahb_sram_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024,
    parameter int SRAM_AW    = $clog2(MEM_DEPTH)
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    input  logic                  hsel,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic [1:0]            htrans,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [2:0]            hburst,
    input  logic [3:0]            hprot,
    input  logic [31:0]           hwdata,
    input  logic                  hready,
    output logic                  hreadyout,
    output logic [1:0]            hresp,
    output logic [31:0]           hrdata,
    output logic                  sram_cs,
    output logic                  sram_we,
    output logic [3:0]            sram_be,
    output logic [SRAM_AW-1:0]    sram_addr,
    output logic [31:0]           sram_wdata,
    input  logic [31:0]           sram_rdata
);

    state_t              r_state;
    state_t              w_next;
    logic [SRAM_AW-1:0]  r_addr;
    logic [3:0]          r_be;
    logic [3:0]          w_be;
    logic                w_bad;
    logic                w_accept;
    logic                w_err;
    logic                w_ready;
    logic [SRAM_AW-1:0]  w_haddr_word;
    logic                w_unused;

    assign w_unused     = ^{hburst, hprot};
    assign w_accept     = hsel & hready & ((htrans == HTRANS_NONSEQ) | (htrans == HTRANS_SEQ));
    assign w_err        = w_accept & w_bad;
    assign w_haddr_word = haddr[SRAM_AW+1:2];

    ahb_sram_be_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH),
        .SRAM_AW    (SRAM_AW)
    ) u_be_gen (
        .i_addr (haddr),
        .i_size (hsize),
        .o_be   (w_be),
        .o_bad  (w_bad)
    );

    // Data-phase ready: only the stall and first error cycle hold the bus.
    always_comb begin
        w_ready = 1'b1;
        case (r_state)
            S_RD_STALL: w_ready = 1'b0;
`ifdef AHB_SRAM_ERR_RESP_EN
            S_ERR1:     w_ready = 1'b0;
`endif
            default:    w_ready = 1'b1;
        endcase
    end

    // State register.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Address-phase capture for the deferred write / stalled read.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_addr <= '0;
            r_be   <= '0;
        end else if (w_ready && w_accept) begin
            r_addr <= w_haddr_word;
            r_be   <= w_be;
        end
    end

    // Next-state selection; ready states decode the current bus request.
    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_RD_STALL: w_next = S_RD;
`ifdef AHB_SRAM_ERR_RESP_EN
            S_ERR1:     w_next = S_ERR2;
`endif
            default: begin
                if (w_err) begin
                    w_next = S_ERR1;
                end else if (w_accept && hwrite) begin
                    w_next = S_WR;
                end else if (w_accept) begin
                    w_next = (r_state == S_WR) ? S_RD_STALL : S_RD;
                end else begin
                    w_next = S_IDLE;
                end
            end
        endcase
    end

    // Bus-side response outputs.
    always_comb begin
        hreadyout = w_ready;
        hresp     = HRESP_OKAY;
        hrdata    = '0;
`ifdef AHB_SRAM_ERR_RESP_EN
        if ((r_state == S_ERR1) || (r_state == S_ERR2)) begin
            hresp = HRESP_ERROR;
        end
`endif
        if (r_state == S_RD) begin
            hrdata = sram_rdata;
        end
    end

    // SRAM port arbitration: data-phase write, then stalled read, then
    // address-phase read; gated by reset so nothing fires while held.
    always_comb begin
        sram_cs    = 1'b0;
        sram_we    = 1'b0;
        sram_be    = '0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (hresetn) begin
            case (r_state)
                S_WR: begin
                    sram_cs    = 1'b1;
                    sram_we    = 1'b1;
                    sram_be    = r_be;
                    sram_addr  = r_addr;
                    sram_wdata = hwdata;
                end
                S_RD_STALL: begin
                    sram_cs   = 1'b1;
                    sram_be   = r_be;
                    sram_addr = r_addr;
                end
                default: begin
                    if (w_ready && w_accept && !hwrite && !w_err) begin
                        sram_cs   = 1'b1;
                        sram_be   = w_be;
                        sram_addr = w_haddr_word;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
AHB-Lite slave that converts bus transfers into accesses on a single-port synchronous SRAM (1-cycle read latency). It is the DUT-side stage that consumes what the AHB master VIP drives and returns hready/hresp/hrdata to it. It supports byte, halfword and word transfers with byte-lane enables. A write data phase followed directly by a read costs one wait state; all other back-to-back transfers run at zero wait.

Parameters:
ADDR_WIDTH, 32, width of haddr.
MEM_DEPTH, 1024, SRAM depth in 32-bit words (power of 2).
SRAM_AW, $clog2(MEM_DEPTH), SRAM word-address width (derived).

Ports:
hclk  in  1  bus clock
hresetn  in  1  async active-low reset
hsel  in  1  slave select
haddr  in  ADDR_WIDTH  byte address
htrans  in  2  IDLE=0 BUSY=1 NONSEQ=2 SEQ=3
hwrite  in  1  1=write
hsize  in  3  0=byte 1=half 2=word
hburst  in  3  ignored
hprot  in  4  ignored
hwdata  in  32  write data (data phase)
hready  in  1  bus-level ready
hreadyout  out  1  slave ready
hresp  out  2  OKAY=0, ERROR=1
hrdata  out  32  read data
sram_cs  out  1  SRAM chip select
sram_we  out  1  SRAM write enable
sram_be  out  4  byte-lane enables
sram_addr  out  SRAM_AW  word address
sram_wdata  out  32  write data
sram_rdata  in  32  read data, valid the cycle after a read cs

Behaviour:
- Clock hclk, reset hresetn, asynchronous, active-low.
- Accept = hsel & hready & htrans[1]. The address phase is registered (addr, be, hwrite) on the accepting edge. IDLE/BUSY or unselected transfers get a zero-wait OKAY with no SRAM access.
- Byte lanes are little-endian:
  - size 0: be = 1<<haddr[1:0].
  - size 1: be = haddr[1] ? 1100 : 0011.
  - size 2: be = 1111.
- hrdata returns the full word; the master selects the lanes.
- FSM states are IDLE, RD, RD_STALL, WR, ERR1, ERR2. In every state whose hreadyout=1, the next state is chosen from the current bus inputs:
  - accept & hwrite -> WR
  - accept & ~hwrite -> RD, or RD_STALL if the current state is WR
  - error -> ERR1
  - otherwise -> IDLE
- State outputs:
  - IDLE: hreadyout=1, hresp=OKAY.
  - WR: SRAM write issued this cycle (cs=1, we=1, registered addr/be, wdata=hwdata); hreadyout=1.
  - RD: SRAM was read during the address phase (cs=1, we=0, addr=haddr[SRAM_AW+1:2]); hrdata=sram_rdata; hreadyout=1.
  - RD_STALL: SRAM read issued with the registered addr; hreadyout=0; unconditionally -> RD.
  - ERR1: hreadyout=0, hresp=ERROR; -> ERR2.
  - ERR2: hreadyout=1, hresp=ERROR; next state per the accept rules.
- SRAM port priority: WR write > RD_STALL read > address-phase read. There is never more than one access per cycle.
- hrdata=0 outside RD. sram_* outputs are 0 when cs=0.
- Reset values: hreadyout=1, hresp=0, hrdata=0, sram_cs=0, sram_we=0, sram_be=0, sram_addr=0, sram_wdata=0, state=IDLE.
- Reset mid-transfer drops any pending write or read; no SRAM access occurs in the reset cycle.

Optional Feature:
AHB_SRAM_ERR_RESP_EN
- Defined: any of the following gives a two-cycle ERROR response and no SRAM access:
  - hsize>2
  - misaligned address (half with haddr[0]=1, word with haddr[1:0]!=0)
  - haddr >= MEM_DEPTH*4
- Undefined: no ERROR is ever generated, and the ERR states are absent.
  - Low address bits are force-aligned to the size.
  - hsize>2 is treated as a word transfer.
  - The address wraps modulo MEM_DEPTH words.

Decomposition:
- Package ahb_sram_pkg holds:
  - the state enum
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ constants
  - HRESP_OKAY/ERROR constants
  - HSIZE_BYTE/HALF/WORD constants
- Sub-module ahb_sram_be_gen: combinational byte-enable generation, plus the alignment/range check feeding the error path.

Test Plan:
- Reset: hold hresetn=0 -> hreadyout=1, hresp=0, sram_cs=0; release -> state IDLE.
- Word write 0xDEADBEEF @0x10, then word read @0x10 -> one stall cycle (hreadyout=0), then hrdata=0xDEADBEEF, OKAY.
- Byte writes 0x11/0x22/0x33/0x44 @0x20..0x23 -> sram_be=0001/0010/0100/1000; word read @0x20 returns 0x44332211 with zero waits after the first.
- Back-to-back reads @0x0,0x4,0x8 (NONSEQ/SEQ) -> no wait states; data appears in consecutive data phases.
- With AHB_SRAM_ERR_RESP_EN: word read @0x2 -> hreadyout 0 then 1, hresp=ERROR both cycles, no sram_cs; the next valid transfer returns OKAY.
- htrans=BUSY/IDLE and hsel=0 cycles interleaved -> no SRAM access, hreadyout=1, OKAY; hresetn asserted during a WR data phase -> no SRAM write.
